int_ctrl: RTL
=============

// Module: int_ctrl
// PURPOSE
//  Interrupt controller feeding the core's interrupt input. It sits upstream of the CPU top.
//  - Synchronises asynchronous external IRQ lines.
//  - Latches each line as edge- or level-sensitive, then masks it.
//  - Merges the core's own timer_int_o back in as the IP7 source.
//  - Drives the 6-bit hardware-interrupt vector sampled into CP0 Cause.IP[7:2].
//  Software accesses a small register window through a load/store-side port.
// PARAMETERS
//  NUM_SRC      5  external IRQ lines, 1..5; mapped to int_o[NUM_SRC-1:0]
//  SYNC_STAGES  2  synchroniser flops per external line, >=2
// PORTS
//  clk          in   1        core clock
//  rst          in   1        asynchronous reset, active-low
//  irq_i        in   NUM_SRC  external interrupt lines, asynchronous, active-high
//  timer_int_i  in   1        core timer interrupt, clk-synchronous, level
//  we_i         in   1        register write strobe
//  waddr_i      in   2        register write address
//  wdata_i      in   32       register write data
//  raddr_i      in   2        register read address
//  rdata_o      out  32       register read data, combinational from raddr_i
//  int_o        out  6        to core int_i; bit5 = timer, bits[NUM_SRC-1:0] = irq_i
// BEHAVIOUR
//  - Reset: all sync flops, edge-history, ENABLE, TRIG, PENDING and int_o go to 0.
//    Reset is asserted asynchronously and released on clk.
//  - Register map:
//    - 0 ENABLE[5:0], RW: bit5 gates the timer, bit i gates irq i.
//    - 1 TRIG[NUM_SRC-1:0], RW: 1 = rising-edge, 0 = level.
//    - 2 PENDING[5:0], RO plus W1C.
//    - 3 ID, see CONFIGURATION.
//    - Unimplemented bits read 0 and ignore writes.
//  - Sync: s_i = irq_i after SYNC_STAGES flops. prev_i = s_i delayed one clk.
//  - Level mode: PENDING[i] <= s_i every cycle; W1C has no effect.
//  - Edge mode: PENDING[i] is set on (s_i & ~prev_i) and cleared by W1C.
//    - A set and a W1C of the same bit in one cycle: set wins, bit stays 1.
//  - Timer: PENDING[5] <= timer_int_i every cycle (level, no sync).
//  - Mode switch: level->edge keeps the current PENDING bit.
//    edge->level makes PENDING follow s_i from the next cycle.
//  - Output: int_o <= PENDING & ENABLE, registered.
//    - Latency from irq_i rise to int_o: SYNC_STAGES+2 clk, i.e. 4 at the default.
//    - Latency from timer_int_i to int_o: 2 clk.
//  - ENABLE write takes effect on int_o one clk after the write edge.
//    Masked sources still accumulate PENDING.
//  - Register writes and source events in the same cycle are resolved per the rules above.
//    No stall or handshake: writes complete in one clk.
//  - An edge pulse narrower than one clk may be lost; sources hold for >= 2 clk.
// CONFIGURATION
//  - INT_CTRL_PRIO_EN defined: register 3 is ID.
//    - ID = {valid[31], 28'b0, id[2:0]}.
//    - id = lowest index i with PENDING[i] & ENABLE[i]; the timer is id 5.
//    - valid = 0 and id = 0 when nothing is pending and enabled.
//    - ID is computed combinationally from the current PENDING and ENABLE registers.
//  - INT_CTRL_PRIO_EN undefined: register 3 reads 0 and no encoder is built.
// TESTING
//  1. Reset with irq_i=5'h1F and timer=1 -> int_o=0 and all registers read 0 while rst=0.
//     After release with ENABLE=0, int_o remains 0.
//  2. ENABLE=6'h01, TRIG=0; irq_i[0] rises at cycle T -> int_o=6'h01 at T+4.
//     irq_i[0] falls -> int_o=0 four cycles after the fall.
//  3. TRIG[1]=1, ENABLE=6'h02; irq_i[1] pulses for 3 clk -> PENDING=6'h02 holds after the fall.
//     W1C 6'h02 -> PENDING=0 next clk.
//     A W1C in the same cycle as a new edge -> PENDING stays 6'h02.
//  4. ENABLE=6'h20, timer_int_i=1 -> int_o=6'h20 two clk later.
//     ENABLE=0 write -> int_o=0 next clk, and PENDING reads 6'h20.
//  5. With INT_CTRL_PRIO_EN: PENDING=6'h2C, ENABLE=6'h28 -> ID reads 32'h8000_0003.
//     ENABLE=0 -> ID reads 0. Without the macro -> register 3 always reads 0.
//  6. Assert rst mid edge-latch with PENDING=6'h04 -> all state cleared immediately.
//     After release, no spurious edge is seen for irq_i held high.

Source files
------------

// File: rtl/int_ctrl_if.sv
// Register-window bus between the load/store side and the interrupt controller.
// The master drives writes and the read address; the slave returns combinational read data.
interface int_ctrl_if;
    logic        we_i;
    logic [1:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [1:0]  raddr_i;
    logic [31:0] rdata_o;

    modport master (output we_i, output waddr_i, output wdata_i, output raddr_i, input rdata_o);
    modport slave  (input we_i, input waddr_i, input wdata_i, input raddr_i, output rdata_o);
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises external IRQs, latches them edge/level, masks, drives int_o.
// Optional priority ID register at address 3 is built only when INT_CTRL_PRIO_EN is defined.
module int_ctrl #(
    parameter int NUM_SRC     = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    int_ctrl_if.slave          bus,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic               timer_int_i,
    output logic [5:0]         int_o
);

    localparam logic [5:0] SRC_MASK  = 6'h20 | 6'((1 << NUM_SRC) - 1);
    localparam logic [1:0] ADDR_EN   = 2'd0;
    localparam logic [1:0] ADDR_TRIG = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_ID   = 2'd3;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_d [SYNC_STAGES];
    logic [4:0]         prev_q, prev_d;
    logic [4:0]         trig_q, trig_d;
    logic [5:0]         en_q, en_d;
    logic [5:0]         pend_q, pend_d;
    logic [5:0]         int_q, int_d;
    logic [4:0]         src_s;
    logic [4:0]         rise;
    logic [5:0]         w1c;
    logic               unused_wdata;

    assign unused_wdata = ^bus.wdata_i[31:6];

    // Sources are padded to 5 bits so absent lines read as permanently low
    always_comb begin
        sync_d[0] = irq_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        src_s = '0;
        src_s[NUM_SRC-1:0] = sync_q[SYNC_STAGES-1];
        prev_d = src_s;
        rise   = src_s & ~prev_q;
    end

    always_comb begin
        w1c = '0;
        if (bus.we_i && (bus.waddr_i == ADDR_PEND)) begin
            w1c = bus.wdata_i[5:0];
        end
        pend_d    = '0;
        pend_d[5] = timer_int_i;
        // Edge mode: a fresh edge beats a same-cycle clear
        for (int i = 0; i < 5; i++) begin
            pend_d[i] = trig_q[i] ? (rise[i] | (pend_q[i] & ~w1c[i])) : src_s[i];
        end
        int_d = pend_q & en_q;
    end

    always_comb begin
        en_d   = en_q;
        trig_d = trig_q;
        if (bus.we_i) begin
            case (bus.waddr_i)
                ADDR_EN:   en_d   = bus.wdata_i[5:0] & SRC_MASK;
                ADDR_TRIG: trig_d = bus.wdata_i[4:0] & SRC_MASK[4:0];
                default:   ;
            endcase
        end
    end

`ifdef INT_CTRL_PRIO_EN
    logic [5:0] act;
    logic [2:0] id;
    logic       id_vld;

    // Scan downward so the lowest active index is the one that sticks
    always_comb begin
        act    = pend_q & en_q;
        id     = '0;
        id_vld = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (act[i]) begin
                id     = 3'(i);
                id_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        bus.rdata_o = '0;
        case (bus.raddr_i)
            ADDR_EN:   bus.rdata_o[5:0] = en_q;
            ADDR_TRIG: bus.rdata_o[4:0] = trig_q;
            ADDR_PEND: bus.rdata_o[5:0] = pend_q;
`ifdef INT_CTRL_PRIO_EN
            ADDR_ID:   bus.rdata_o = {id_vld, 28'b0, id};
`else
            ADDR_ID:   bus.rdata_o = '0;
`endif
            default:   bus.rdata_o = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
            trig_q <= '0;
            en_q   <= '0;
            pend_q <= '0;
            int_q  <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q <= prev_d;
            trig_q <= trig_d;
            en_q   <= en_d;
            pend_q <= pend_d;
            int_q  <= int_d;
        end
    end

    assign int_o = int_q;

endmodule
